// File: rtl/i2s_audio_dac_transmitter_if.sv
// rtl/i2s_audio_dac_transmitter_if.sv - stereo sample handshake between sample source and I2S transmitter
interface i2s_audio_dac_transmitter_if #(
    parameter int w_sample = 16
);
    logic [w_sample-1:0] left;
    logic [w_sample-1:0] right;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output left,
        output right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left,
        input  right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_audio_dac_transmitter.sv
// rtl/i2s_audio_dac_transmitter.sv - I2S master transmitter for a stereo DAC, Philips format, MSB first
module i2s_audio_dac_transmitter #(
    parameter int w_sample      = 16,
    parameter int slot_bits     = 32,
    parameter int bclk_half_div = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    i2s_audio_dac_transmitter_if.slave    smp,
    output logic                          frame_start,
    output logic                          underflow,
    output logic                          bclk,
    output logic                          ws,
    output logic                          sd
);
    localparam int frame_len = 2 * slot_bits;
    localparam int pw        = $clog2(frame_len);
    localparam int dw        = $clog2(bclk_half_div);

    localparam logic [dw-1:0] div_max  = dw'(bclk_half_div - 1);
    localparam logic [pw-1:0] pos_max  = pw'(frame_len - 1);
    localparam logic [pw-1:0] slot_len = pw'(slot_bits);
    localparam logic [pw-1:0] w_len    = pw'(w_sample);

    logic [dw-1:0]       div_cnt;
    logic [pw-1:0]       pos;
    logic                full;
    logic [w_sample-1:0] hold_l;
    logic [w_sample-1:0] hold_r;
    logic [w_sample-1:0] frame_l;
    logic [w_sample-1:0] frame_r;

    logic                fall_evt;
    logic                load_evt;
    logic                accept;
    logic [pw-1:0]       pos_next;
    logic [pw-1:0]       slot_pos;
    logic [pw-1:0]       bit_idx;
    logic [w_sample-1:0] slot_word;
    logic [w_sample-1:0] bit_mask;
    logic                ws_next;
    logic                sd_next;

    // Ready is forced low during reset so nothing is accepted into a register being cleared.
    assign smp.sample_ready = !full && !rst;
    assign accept           = smp.sample_valid && smp.sample_ready;
    assign fall_evt         = (div_cnt == div_max) && bclk;
    assign load_evt         = fall_evt && (pos_next == '0);

    // Next frame position and the ws/sd values to present after the coming BCLK fall.
    always_comb begin
        pos_next  = (pos == pos_max) ? '0 : pos + 1'b1;
        ws_next   = (pos_next >= slot_len);
        slot_pos  = ws_next ? (pos_next - slot_len) : pos_next;
        bit_idx   = w_len - slot_pos;
        slot_word = ws_next ? frame_r : frame_l;
        bit_mask  = w_sample'(1) << bit_idx;
        sd_next   = 1'b0;
        if ((slot_pos != '0) && (slot_pos <= w_len)) begin
            sd_next = |(slot_word & bit_mask);
        end
    end

    // BCLK divider: toggle bclk every bclk_half_div clk cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_cnt == div_max) begin
            div_cnt <= '0;
            bclk    <= !bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Serialiser: ws/sd and frame position only move on BCLK falls; frame data reloads at position 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos     <= pos_max;
            ws      <= 1'b0;
            sd      <= 1'b0;
            frame_l <= '0;
            frame_r <= '0;
        end else if (fall_evt) begin
            pos <= pos_next;
            ws  <= ws_next;
            sd  <= sd_next;
            if (load_evt) begin
                frame_l <= full ? hold_l : '0;
                frame_r <= full ? hold_r : '0;
            end
        end
    end

    // One-entry holding register; a sample accepted during an empty load waits for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else if (accept) begin
            full   <= 1'b1;
            hold_l <= smp.left;
            hold_r <= smp.right;
        end else if (load_evt && full) begin
            full <= 1'b0;
        end
    end

    // Frame status pulses, one cycle after the loading fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            frame_start <= load_evt;
            underflow   <= load_evt && !full;
        end
    end
endmodule

// File: tb/tb_i2s_audio_dac_transmitter.sv
// tb/tb_i2s_audio_dac_transmitter.sv - self-checking bench for the I2S DAC transmitter
module tb_i2s_audio_dac_transmitter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_audio_dac_transmitter_if #(.w_sample(W)) bus ();

    logic frame_start, underflow, bclk, ws, sd;

    i2s_audio_dac_transmitter #(
        .w_sample(W),
        .slot_bits(32),
        .bclk_half_div(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .smp(bus.slave),
        .frame_start(frame_start),
        .underflow(underflow),
        .bclk(bclk),
        .ws(ws),
        .sd(sd)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: n = clk edges since the last edge that saw rst high. bclk period 8 clk,
    // a BCLK fall every 8 edges, frame of 64 BCLKs = 512 edges, frame loads at n = 8 + 512k.
    int          n = 0;
    bit          started = 0;
    bit          m_full = 0;
    logic [15:0] m_hl = '0, m_hr = '0, m_cl = '0, m_cr = '0;
    bit          e_fs = 0, e_uf = 0;

    function automatic bit load_at(input int k);
        return (k % 512) == 8;
    endfunction

    function automatic bit exp_ws(input int k);
        int f;
        f = k / 8;
        if (f == 0) return 1'b0;
        return ((f - 1) % 64) >= 32;
    endfunction

    function automatic bit exp_sd(input int k, input logic [15:0] l, input logic [15:0] r);
        int f, pos, p;
        logic [15:0] w;
        f = k / 8;
        if (f == 0) return 1'b0;
        pos = (f - 1) % 64;
        p   = pos % 32;
        if (p < 1 || p > 16) return 1'b0;
        w = (pos >= 32) ? r : l;
        return w[16 - p];
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            n      <= 0;
            m_full <= 1'b0;
            m_hl   <= '0;
            m_hr   <= '0;
            m_cl   <= '0;
            m_cr   <= '0;
            e_fs   <= 1'b0;
            e_uf   <= 1'b0;
        end else begin
            n    <= n + 1;
            e_fs <= load_at(n + 1);
            e_uf <= load_at(n + 1) && !m_full;
            if (load_at(n + 1)) begin
                m_cl <= m_full ? m_hl : 16'h0;
                m_cr <= m_full ? m_hr : 16'h0;
            end
            if (bus.sample_valid && !m_full) begin
                m_hl   <= bus.left;
                m_hr   <= bus.right;
                m_full <= 1'b1;
            end else if (load_at(n + 1) && m_full) begin
                m_full <= 1'b0;
            end
        end
    end

    bit prev_ws = 0, prev_bclk = 0;
    int fs_cnt = 0, uf_cnt = 0, sd_cnt = 0;

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            check("bclk", bclk, ((n / 4) % 2));
            check("ws", ws, exp_ws(n));
            check("sd", sd, exp_sd(n, m_cl, m_cr));
            check("frame_start", frame_start, e_fs);
            check("underflow", underflow, e_uf);
            check("sample_ready", bus.sample_ready, (!m_full && !rst));
            if (n > 0 && ws !== prev_ws)
                check("ws_edge_on_bclk_fall", {prev_bclk, bclk}, 2'b10);
            prev_ws   <= ws;
            prev_bclk <= bclk;
            if (frame_start) fs_cnt <= fs_cnt + 1;
            if (underflow)   uf_cnt <= uf_cnt + 1;
            if (sd)          sd_cnt <= sd_cnt + 1;
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int t;
        bus.left         = l;
        bus.right        = r;
        bus.sample_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.sample_ready) break;
            t++;
            if (t > 2000) begin
                check("send_timeout", 1, 0);
                bus.sample_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #2;
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_start && cyc < 2000);
        if (!frame_start) check("frame_start_timeout", 0, 1);
    endtask

    task automatic capture(output logic [63:0] word, output bit uf);
        bit prev;
        int rises, t;
        wait_fs();
        uf    = underflow;
        word  = '0;
        prev  = bclk;
        rises = 0;
        t     = 0;
        while (rises < 64 && t < 1000) begin
            @(negedge clk);
            t++;
            if (bclk && !prev) begin
                word = {word[62:0], sd};
                rises++;
            end
            prev = bclk;
        end
        if (rises < 64) check("capture_timeout", rises, 64);
    endtask

    logic [63:0] w1, w2;
    bit          u1, u2;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int cnt, hi, br, t, k;
        bit pb;
        int fs0, uf0, sd0;

        bus.left         = '0;
        bus.right        = '0;
        bus.sample_valid = 1'b0;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Sample accepted before the first fall plays in the first frame.
        fork
            send(16'hA5F0, 16'h1234);
            capture(w1, u1);
        join
        check("t2_frame", w1, 64'h52F80000_091A0000);
        check("t2_underflow", u1, 0);

        // Clock ratios: ws period 512, 50% duty, 64 bclk rises per frame.
        t = 0;
        @(negedge clk);
        pb = ws;
        while (!(ws && !pb) && t < 1000) begin
            pb = ws;
            @(negedge clk);
            t++;
        end
        cnt = 0; hi = 0; br = 0;
        pb = ws;
        begin
            bit pbclk;
            pbclk = bclk;
            do begin
                @(negedge clk);
                cnt++;
                if (ws) hi++;
                if (bclk && !pbclk) br++;
                pbclk = bclk;
                if (ws && !pb) break;
                pb = ws;
            end while (cnt < 1000);
        end
        check("t1_ws_period", cnt, 512);
        check("t1_ws_high", hi, 256);
        check("t1_bclk_rises", br, 64);

        // Idle: exactly one frame_start and one underflow per 512 clk, sd silent.
        fs0 = fs_cnt; uf0 = uf_cnt; sd0 = sd_cnt;
        repeat (1024) @(negedge clk);
        @(posedge clk);
        check("t3_frame_starts", fs_cnt - fs0, 2);
        check("t3_underflows", uf_cnt - uf0, 2);
        check("t3_sd_ones", sd_cnt - sd0, 0);
        #2;

        // Backpressure: two pairs back to back play in order.
        fork
            begin
                send(16'h8000, 16'hFFFF);
                send(16'h0001, 16'h7FFF);
            end
            begin
                capture(w1, u1);
                capture(w2, u2);
            end
        join
        check("t4_frame1", w1, 64'h40000000_7FFF8000);
        check("t4_uf1", u1, 0);
        check("t4_frame2", w2, 64'h00008000_3FFF8000);
        check("t4_uf2", u2, 0);

        // Accept on the same edge as an empty-holding load.
        t = 0;
        do begin
            @(posedge clk);
            #2;
            t++;
        end while ((n % 512) != 7 && t < 1000);
        bus.left         = 16'h0F0F;
        bus.right        = 16'hF00F;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #2;
        bus.sample_valid = 1'b0;
        capture(w1, u1);
        check("t5_frame_zero", w1, 64'h0);
        check("t5_underflow", u1, 1);
        capture(w2, u2);
        check("t5_frame_next", w2, 64'h07878000_78078000);
        check("t5_uf_next", u2, 0);

        // Reset mid right slot with a sample pending.
        @(posedge clk);
        #2;
        send(16'h5555, 16'hAAAA);
        t = 0;
        do begin
            @(posedge clk);
            #2;
            t++;
        end while ((n % 512) != 308 && t < 1000);
        check("t6_in_right_slot", ws, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_reset_outputs", {bclk, ws, sd, bus.sample_ready, frame_start, underflow}, 6'b0);
        #1 rst = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!frame_start && k < 100);
        check("t6_first_fall_edges", k, 8);
        check("t6_underflow_pending_dropped", underflow, 1);
        capture(w1, u1);
        check("t6_next_frame_zero", w1, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
